// File: rtl/riscv_mem_req_queue.sv
// Purpose: in-order request FIFO between the I$/D$ arbiter and memory, with an in-flight read cap and a registered response path.
// Latency: request 1 cycle minimum in->out (no bypass); response exactly 1 cycle.
// Backpressure: in_req_ready comes from occupancy only; a head read stalls while MAX_OUT reads are in flight; responses are never stalled.
//
// Ports:
//   clk, reset                      single clock, synchronous active-high reset
//   in_req_*  (valid/ready/rw/addr/tag)   arbitrated request in
//   out_req_* (valid/ready/rw/addr/tag)   request to memory, driven from the head entry
//   mem_resp_valid, mem_resp_tag    read response from memory
//   resp_valid, resp_tag            response re-timed by one register back to the arbiter
//   count                           FIFO occupancy
//   err                             sticky: response arrived with no read in flight

`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 4
`endif

module riscv_mem_req_queue #(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 8,
  parameter int ADDR_W  = `MEM_ADDR_BITS,
  parameter int TAG_W   = `MEM_TAG_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_req_valid,
  output logic                   in_req_ready,
  input  logic                   in_req_rw,
  input  logic [ADDR_W-1:0]      in_req_addr,
  input  logic [TAG_W-1:0]       in_req_tag,
  output logic                   out_req_valid,
  input  logic                   out_req_ready,
  output logic                   out_req_rw,
  output logic [ADDR_W-1:0]      out_req_addr,
  output logic [TAG_W-1:0]       out_req_tag,
  input  logic                   mem_resp_valid,
  input  logic [TAG_W-1:0]       mem_resp_tag,
  output logic                   resp_valid,
  output logic [TAG_W-1:0]       resp_tag,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
  } req_t;

  req_t             slots [DEPTH];
  req_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OUT_W-1:0] outstanding;
  logic             enq;
  logic             deq;
  logic             rd_issue;
  logic             cap_ok;

  // Ready is a pure function of registered state, so memory-side ready
  // never reaches back combinationally to the caches.
  assign in_req_ready = (count != CNT_W'(DEPTH)) & ~reset;
  assign enq          = in_req_valid & in_req_ready;

  assign head         = slots[rd_ptr];
  assign out_req_rw   = head.rw;
  assign out_req_addr = head.addr;
  assign out_req_tag  = head.tag;

  // Writes get no response, so only reads are held back by the cap.
  assign cap_ok        = outstanding < OUT_W'(MAX_OUT);
  assign out_req_valid = (count != '0) & (head.rw | cap_ok);
  assign deq           = out_req_valid & out_req_ready;
  assign rd_issue      = deq & ~head.rw;

  // Storage carries no reset; entries are only observed once count covers them.
  always_ff @(posedge clk) begin
    if (enq) begin
      slots[wr_ptr] <= '{rw: in_req_rw, addr: in_req_addr, tag: in_req_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      if (enq && !deq)      count <= count + CNT_W'(1);
      else if (deq && !enq) count <= count - CNT_W'(1);
    end
  end

  // A response with nothing in flight (and no read issuing to cover it) is a
  // protocol error; the counter clamps at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
      err         <= 1'b0;
    end else if (rd_issue && !mem_resp_valid) begin
      outstanding <= outstanding + OUT_W'(1);
    end else if (!rd_issue && mem_resp_valid) begin
      if (outstanding != '0) outstanding <= outstanding - OUT_W'(1);
      else                   err         <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_tag   <= '0;
    end else begin
      resp_valid <= mem_resp_valid;
      resp_tag   <= mem_resp_tag;
    end
  end

endmodule

// File: tb/tb_riscv_mem_req_queue.sv
// Purpose: self-checking bench for riscv_mem_req_queue (DEPTH=4; MAX_OUT=8 main instance, MAX_OUT=2 throttle instance).
// Latency: checks 1-cycle request and response latency.
// Backpressure: exercises full-queue stall, read cap stall, and write pass-through behind a stalled read.

module tb_riscv_mem_req_queue;

  localparam int AW = 32;
  localparam int TW = 4;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [TW-1:0] tag;
  } req_t;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [TW-1:0] tag;
    int            exp_count;
  } vec_t;

  bit            clk;
  logic          reset;
  logic          in_req_valid;
  logic          in_req_rw;
  logic [AW-1:0] in_req_addr;
  logic [TW-1:0] in_req_tag;
  logic          out_req_ready;
  logic          mem_resp_valid;
  logic [TW-1:0] mem_resp_tag;

  logic          in_req_ready,  in_req_ready_t;
  logic          out_req_valid, out_req_valid_t;
  logic          out_req_rw,    out_req_rw_t;
  logic [AW-1:0] out_req_addr,  out_req_addr_t;
  logic [TW-1:0] out_req_tag,   out_req_tag_t;
  logic          resp_valid,    resp_valid_t;
  logic [TW-1:0] resp_tag,      resp_tag_t;
  logic [2:0]    count,         count_t;
  logic          err,           err_t;

  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 0;
  bit   exp_rv   = 0;
  logic [TW-1:0] exp_rt;
  req_t sbq [$];

  riscv_mem_req_queue #(.DEPTH(4), .MAX_OUT(8), .ADDR_W(AW), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_ready(in_req_ready),
    .in_req_rw(in_req_rw), .in_req_addr(in_req_addr), .in_req_tag(in_req_tag),
    .out_req_valid(out_req_valid), .out_req_ready(out_req_ready),
    .out_req_rw(out_req_rw), .out_req_addr(out_req_addr), .out_req_tag(out_req_tag),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag),
    .resp_valid(resp_valid), .resp_tag(resp_tag),
    .count(count), .err(err)
  );

  riscv_mem_req_queue #(.DEPTH(4), .MAX_OUT(2), .ADDR_W(AW), .TAG_W(TW)) dut2 (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_ready(in_req_ready_t),
    .in_req_rw(in_req_rw), .in_req_addr(in_req_addr), .in_req_tag(in_req_tag),
    .out_req_valid(out_req_valid_t), .out_req_ready(out_req_ready),
    .out_req_rw(out_req_rw_t), .out_req_addr(out_req_addr_t), .out_req_tag(out_req_tag_t),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag),
    .resp_valid(resp_valid_t), .resp_tag(resp_tag_t),
    .count(count_t), .err(err_t)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    in_req_valid   = 1'b0;
    out_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check("rst_hold_in_ready", in_req_ready, 0);
    tick();
    reset = 1'b0;
  endtask

  task automatic drive_req(input logic rw, input logic [AW-1:0] addr, input logic [TW-1:0] tag);
    in_req_valid = 1'b1;
    in_req_rw    = rw;
    in_req_addr  = addr;
    in_req_tag   = tag;
  endtask

  // Scoreboards: request order on the main instance, and 1-cycle response re-timing.
  always @(negedge clk) begin
    if (mon_en) begin
      if (resp_valid || exp_rv) begin
        check("resp_valid_sb", resp_valid, exp_rv);
        if (exp_rv) check("resp_tag_sb", resp_tag, exp_rt);
      end
      exp_rv = !reset && mem_resp_valid;
      exp_rt = mem_resp_tag;
      if (reset) begin
        sbq.delete();
      end else begin
        if (out_req_valid && out_req_ready) begin
          if (sbq.size() == 0) begin
            check("sb_unexpected_issue", out_req_valid, 0);
          end else begin
            req_t e;
            e = sbq.pop_front();
            check("sb_addr", out_req_addr, e.addr);
            check("sb_rw",   out_req_rw,   e.rw);
            check("sb_tag",  out_req_tag,  e.tag);
          end
        end
        if (in_req_valid && in_req_ready)
          sbq.push_back('{rw: in_req_rw, addr: in_req_addr, tag: in_req_tag});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    vec_t vecs [10];
    int   accepted;
    int   n_rd;

    reset = 1'b1; in_req_valid = 1'b0; in_req_rw = 1'b0; in_req_addr = '0; in_req_tag = '0;
    out_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_tag = '0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready_low", in_req_ready, 0);
    check("rst_out_valid",    out_req_valid, 0);
    tick();
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_in_ready_high", in_req_ready, 1);
    check("rst_count",         count, 0);
    check("rst_err",           err, 0);
    check("rst_resp_valid",    resp_valid, 0);
    check("rst_outstanding",   dut.outstanding, 0);
    tick();

    // Single read: enqueue cycle 1, issue cycle 2, response cycle 6 -> resp cycle 7
    do_reset();
    out_req_ready = 1'b1;
    drive_req(1'b0, 32'h100, 4'd0);
    @(negedge clk);
    check("t1_no_bypass", out_req_valid, 0);
    tick();
    in_req_valid = 1'b0;
    @(negedge clk);
    check("t1_out_valid", out_req_valid, 1);
    check("t1_out_addr",  out_req_addr, 32'h100);
    check("t1_out_tag",   out_req_tag, 0);
    tick();
    @(negedge clk);
    check("t1_outstanding_1", dut.outstanding, 1);
    check("t1_out_idle",      out_req_valid, 0);
    tick(); tick(); tick();
    mem_resp_valid = 1'b1;
    mem_resp_tag   = 4'd0;
    tick();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check("t1_resp_valid",    resp_valid, 1);
    check("t1_resp_tag",      resp_tag, 0);
    check("t1_outstanding_0", dut.outstanding, 0);
    check("t1_err",           err, 0);
    tick();

    // Fill: 5 offered with memory stalled, 4 accepted, drained in order
    do_reset();
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      drive_req(i[0], 32'(32'h10 + i), 4'(i));
      @(negedge clk);
      if (in_req_ready) accepted++;
      tick();
    end
    in_req_valid = 1'b0;
    @(negedge clk);
    check("t2_accepted", accepted, 4);
    check("t2_count",    count, 4);
    check("t2_in_ready", in_req_ready, 0);
    tick();
    out_req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t2_drain_valid", out_req_valid, 1);
      check("t2_drain_addr",  out_req_addr, 32'(32'h10 + k));
      tick();
    end
    @(negedge clk);
    check("t2_empty_count", count, 0);
    check("t2_empty_valid", out_req_valid, 0);
    tick();

    // Simultaneous enqueue/dequeue at count 2 across pointer wrap
    n_rd = 2;
    for (int i = 0; i < 10; i++) begin
      vecs[i] = '{rw: i[0], addr: 32'(32'h400 + i), tag: 4'(i), exp_count: 2};
      if (!i[0]) n_rd++;
    end
    do_reset();
    drive_req(1'b0, 32'h200, 4'hA);
    tick();
    drive_req(1'b0, 32'h201, 4'hB);
    tick();
    out_req_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_req(vecs[i].rw, vecs[i].addr, vecs[i].tag);
      @(negedge clk);
      check("t3_count",     count, vecs[i].exp_count);
      check("t3_out_valid", out_req_valid, 1);
      tick();
    end
    in_req_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("t3_drained_count", count, 0);
    check("t3_sb_left",       sbq.size(), 0);
    check("t3_outstanding",   dut2.outstanding <= 2 ? dut.outstanding : 4'hF, n_rd);
    tick();

    // Throttle (MAX_OUT=2 instance): R,R,R,W with no responses
    do_reset();
    drive_req(1'b0, 32'h300, 4'd1); tick();
    drive_req(1'b0, 32'h301, 4'd2); tick();
    drive_req(1'b0, 32'h302, 4'd3); tick();
    drive_req(1'b1, 32'h303, 4'd4); tick();
    in_req_valid  = 1'b0;
    out_req_ready = 1'b1;
    @(negedge clk);
    check("t4_r1_valid", out_req_valid_t, 1);
    check("t4_r1_addr",  out_req_addr_t, 32'h300);
    tick();
    @(negedge clk);
    check("t4_r2_valid", out_req_valid_t, 1);
    check("t4_r2_addr",  out_req_addr_t, 32'h301);
    tick();
    @(negedge clk);
    check("t4_r3_blocked",   out_req_valid_t, 0);
    check("t4_r3_head_addr", out_req_addr_t, 32'h302);
    check("t4_outstanding",  dut2.outstanding, 2);
    check("t4_count",        count_t, 2);
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_tag   = 4'd1;
    @(negedge clk);
    check("t4_still_blocked", out_req_valid_t, 0);
    check("t4_head_stable",   out_req_addr_t, 32'h302);
    tick();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check("t4_r3_valid", out_req_valid_t, 1);
    check("t4_r3_addr",  out_req_addr_t, 32'h302);
    check("t4_r3_rw",    out_req_rw_t, 0);
    tick();
    @(negedge clk);
    check("t4_w_valid", out_req_valid_t, 1);
    check("t4_w_addr",  out_req_addr_t, 32'h303);
    check("t4_w_rw",    out_req_rw_t, 1);
    tick();
    @(negedge clk);
    check("t4_final_count", count_t, 0);
    check("t4_final_out",   dut2.outstanding, 2);
    tick();

    // Underflow: response with nothing in flight
    do_reset();
    mem_resp_valid = 1'b1;
    mem_resp_tag   = 4'd1;
    tick();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check("t5_resp_valid",   resp_valid, 1);
    check("t5_resp_tag",     resp_tag, 1);
    check("t5_err",          err, 1);
    check("t5_outstanding",  dut.outstanding, 0);
    tick(); tick();
    @(negedge clk);
    check("t5_err_sticky",   err, 1);
    check("t5_resp_idle",    resp_valid, 0);
    check("t5_outstanding2", dut.outstanding, 0);
    tick();

    // Reset mid-operation with count 3 and outstanding 2
    do_reset();
    out_req_ready = 1'b1;
    drive_req(1'b0, 32'h500, 4'd1); tick();
    drive_req(1'b0, 32'h501, 4'd2); tick();
    drive_req(1'b0, 32'h502, 4'd3); tick();
    out_req_ready = 1'b0;
    drive_req(1'b0, 32'h503, 4'd4); tick();
    drive_req(1'b0, 32'h504, 4'd5); tick();
    in_req_valid = 1'b0;
    @(negedge clk);
    check("t6_pre_count", count, 3);
    check("t6_pre_out",   dut.outstanding, 2);
    tick();
    do_reset();
    @(negedge clk);
    check("t6_count",       count, 0);
    check("t6_outstanding", dut.outstanding, 0);
    check("t6_out_valid",   out_req_valid, 0);
    check("t6_in_ready",    in_req_ready, 1);
    check("t6_err_clear",   err, 0);
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_tag   = 4'd6;
    tick();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check("t6_late_resp",     resp_valid, 1);
    check("t6_late_resp_tag", resp_tag, 6);
    check("t6_late_err",      err, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
